ecdsa_avalon_regs: RTL and testbench



---
 rtl/ecdsa_avalon_regs.sv | 233 +++++++++++++++++++++++
 tb/tb_ecdsa_avalon_regs.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecdsa_avalon_regs.sv
// ---------------------------------------------------------------------------
// ecdsa_avalon_regs
//
// Avalon-MM slave register file and run controller for the ECDSA core.
// Software loads a 256-bit private key (words 0-7) and a 96-bit message
// (words 8-10), then writes start. The operands are snapshotted into shadow
// registers that stay stable for the whole run; the core's done/invalid
// result is captured into readable status, and a cycle timeout aborts a hung
// core.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   avs_*               Avalon-MM slave (word address 0-15, 1-cycle read)
//   core_priv_key       shadow key {reg7..reg0}
//   core_message        shadow message {reg10,reg9,reg8}
//   core_start          high only while running
//   core_done           core done level
//   core_invalid        core invalid_error level
//   irq                 high while DONE and irq-enable is set
// ---------------------------------------------------------------------------
module ecdsa_avalon_regs #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [3:0]   avs_address,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic [3:0]   avs_byteenable,
    input  logic [31:0]  avs_writedata,
    output logic [31:0]  avs_readdata,
    output logic [255:0] core_priv_key,
    output logic [95:0]  core_message,
    output logic         core_start,
    input  logic         core_done,
    input  logic         core_invalid,
    output logic         irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0][31:0]    key_q, key_d;
    logic [2:0][31:0]    msg_q, msg_d;
    logic                irqen_q, irqen_d;
    logic                start_q, start_d;
    logic                invalid_q, invalid_d;
    logic                timeout_q, timeout_d;
    logic [31:0]         count_q, count_d;
    logic [255:0]        sh_key_q, sh_key_d;
    logic [95:0]         sh_msg_q, sh_msg_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                core_start_q, core_start_d;
    logic                done_q, done_d;
    logic                irq_q, irq_d;

    logic                start_wr_s;
    logic                start_bit_s;
    logic                timeout_hit_s;
    logic [31:0]         rd_mux_s;

    // Merge write data into an existing word, one byte lane per enable bit.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // A start-register write only counts when lane 0 (which holds bit0) is enabled.
    assign start_wr_s    = avs_write && (avs_address == 4'd14) && avs_byteenable[0];
    assign start_bit_s   = avs_writedata[0];
    assign timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) && (count_q == (TIMEOUT_CYCLES - 32'd1));

    // Front register file: software-visible RW words with byte-lane writes.
    always_comb begin
        key_d   = key_q;
        msg_d   = msg_q;
        irqen_d = irqen_q;
        start_d = start_q;
        if (avs_write) begin
            case (avs_address)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                    key_d[avs_address[2:0]] = byte_merge(key_q[avs_address[2:0]], avs_writedata, avs_byteenable);
                4'd8:  msg_d[0] = byte_merge(msg_q[0], avs_writedata, avs_byteenable);
                4'd9:  msg_d[1] = byte_merge(msg_q[1], avs_writedata, avs_byteenable);
                4'd10: msg_d[2] = byte_merge(msg_q[2], avs_writedata, avs_byteenable);
                4'd11: irqen_d  = avs_byteenable[0] ? avs_writedata[0] : irqen_q;
                4'd14: start_d  = avs_byteenable[0] ? avs_writedata[0] : start_q;
                default: ;
            endcase
        end else begin
            key_d = key_q;
        end
    end

    // Run controller: snapshots operands, counts run cycles, captures result.
    always_comb begin
        state_d   = state_q;
        sh_key_d  = sh_key_q;
        sh_msg_d  = sh_msg_q;
        invalid_d = invalid_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start_wr_s && start_bit_s) begin
                    state_d   = ST_RUN;
                    sh_key_d  = key_q;
                    sh_msg_d  = msg_q;
                    invalid_d = 1'b0;
                    timeout_d = 1'b0;
                    count_d   = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A software abort wins; status and count freeze where they are.
                if (start_wr_s && !start_bit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = (count_q == 32'hFFFF_FFFF) ? count_q : (count_q + 32'd1);
                    // Done is checked first so a result on the timeout cycle is kept.
                    if (core_done) begin
                        state_d   = ST_DONE;
                        invalid_d = core_invalid;
                        timeout_d = 1'b0;
                    end else if (timeout_hit_s) begin
                        state_d   = ST_DONE;
                        invalid_d = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                // Only an explicit start=0 acknowledges; start=1 here is ignored.
                if (start_wr_s && !start_bit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flags are decoded from the next state so they line up with state_q.
    always_comb begin
        core_start_d = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
        irq_d        = (state_d == ST_DONE) && irqen_d;
    end

    // Read mux over current register values, so a same-cycle write is not seen.
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs_address)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                   rd_mux_s = key_q[avs_address[2:0]];
            4'd8:  rd_mux_s = msg_q[0];
            4'd9:  rd_mux_s = msg_q[1];
            4'd10: rd_mux_s = msg_q[2];
            4'd11: rd_mux_s = {31'd0, irqen_q};
            4'd12: rd_mux_s = {29'd0, (state_q == ST_RUN), timeout_q, invalid_q};
            4'd13: rd_mux_s = count_q;
            4'd14: rd_mux_s = {31'd0, start_q};
            4'd15: rd_mux_s = {31'd0, done_q};
            default: rd_mux_s = 32'd0;
        endcase
        if (avs_read) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and register update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            msg_q        <= '0;
            irqen_q      <= 1'b0;
            start_q      <= 1'b0;
            invalid_q    <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= 32'd0;
            sh_key_q     <= 256'd0;
            sh_msg_q     <= 96'd0;
            rdata_q      <= 32'd0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            msg_q        <= msg_d;
            irqen_q      <= irqen_d;
            start_q      <= start_d;
            invalid_q    <= invalid_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
            sh_key_q     <= sh_key_d;
            sh_msg_q     <= sh_msg_d;
            rdata_q      <= rdata_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            irq_q        <= irq_d;
        end
    end

    assign avs_readdata  = rdata_q;
    assign core_priv_key = sh_key_q;
    assign core_message  = sh_msg_q;
    assign core_start    = core_start_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_ecdsa_avalon_regs.sv
module tb_ecdsa_avalon_regs;

    logic         clk;
    logic         reset_n;
    logic [3:0]   avs_address;
    logic         avs_read;
    logic         avs_write;
    logic [3:0]   avs_byteenable;
    logic [31:0]  avs_writedata;
    logic [31:0]  avs_readdata;
    logic [255:0] core_priv_key;
    logic [95:0]  core_message;
    logic         core_start;
    logic         core_done;
    logic         core_invalid;
    logic         irq;

    int checks = 0;
    int errors = 0;

    ecdsa_avalon_regs #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_byteenable (avs_byteenable),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .core_priv_key  (core_priv_key),
        .core_message   (core_message),
        .core_start     (core_start),
        .core_done      (core_done),
        .core_invalid   (core_invalid),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        avs_address    = addr;
        avs_writedata  = data;
        avs_byteenable = be;
        avs_write      = 1'b1;
        @(negedge clk);
        avs_write      = 1'b0;
        avs_byteenable = 4'h0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", a, rd, 32'h0);
            end
        end
        checks++;
        if (irq !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs irq=%b core_start=%b exp 0/0", irq, core_start);
        end
        checks++;
        if (core_priv_key !== 256'd0 || core_message !== 96'd0) begin
            errors++;
            $display("FAIL reset_shadows key=%h msg=%h exp 0", core_priv_key, core_message);
        end
    endtask

    task automatic test_normal_run();
        logic [255:0] exp_key;
        logic [95:0]  exp_msg;
        logic [31:0]  rd;
        int           high_cnt;
        for (int i = 0; i < 8; i++) begin
            bus_write(4'(i), 32'h1111_1111 * 32'(i + 1), 4'hF);
            exp_key[32*i +: 32] = 32'h1111_1111 * 32'(i + 1);
        end
        bus_write(4'd8,  32'hA0A0_0001, 4'hF);
        bus_write(4'd9,  32'hA0A0_0002, 4'hF);
        bus_write(4'd10, 32'hA0A0_0003, 4'hF);
        exp_msg = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001};
        checks++;
        if (core_priv_key !== 256'd0) begin
            errors++;
            $display("FAIL shadow_before_start got=%h exp=0", core_priv_key);
        end
        bus_write(4'd14, 32'h1, 4'h1);
        checks++;
        if (core_priv_key !== exp_key || core_message !== exp_msg) begin
            errors++;
            $display("FAIL shadow_after_start key=%h exp=%h msg=%h exp=%h", core_priv_key, exp_key, core_message, exp_msg);
        end
        high_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (core_start) begin
                high_cnt++;
                if (high_cnt == 10) core_done = 1'b1;
            end else if (high_cnt > 0) begin
                break;
            end
            @(negedge clk);
        end
        core_done = 1'b0;
        checks++;
        if (high_cnt !== 10) begin
            errors++;
            $display("FAIL run_length got=%0d exp=%0d", high_cnt, 10);
        end
        bus_read(4'd15, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL done_reg got=%h exp=%h", rd, 32'h1); end
        bus_read(4'd12, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL status_ok got=%h exp=%h", rd, 32'h0); end
        bus_read(4'd13, rd);
        checks++;
        if (rd !== 32'd10) begin errors++; $display("FAIL cycle_count got=%0d exp=%0d", rd, 10); end
        bus_read(4'd14, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL start_readback got=%h exp=%h", rd, 32'h1); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled got=%b exp=0", irq); end
        bus_write(4'd14, 32'h0, 4'h1);
        bus_read(4'd15, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL done_cleared got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_invalid_irq();
        logic [31:0] rd;
        int          wait_cnt;
        bus_write(4'd11, 32'h1, 4'hF);
        bus_write(4'd14, 32'h1, 4'h1);
        for (int c = 0; c < 4; c++) @(negedge clk);
        core_done    = 1'b1;
        core_invalid = 1'b1;
        wait_cnt = 0;
        while (core_start && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        core_done    = 1'b0;
        core_invalid = 1'b0;
        bus_read(4'd12, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL status_invalid got=%h exp=%h", rd, 32'h1); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", irq); end
        // start=1 while DONE must not restart the core
        bus_write(4'd14, 32'h1, 4'h1);
        @(negedge clk);
        checks++;
        if (core_start !== 1'b0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL done_ignores_start core_start=%b irq=%b exp 0/1", core_start, irq);
        end
        bus_write(4'd14, 32'h0, 4'h1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got=%b exp=0", irq); end
        bus_read(4'd12, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL status_kept got=%h exp=%h", rd, 32'h1); end
        bus_write(4'd11, 32'h0, 4'hF);
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        int          high_cnt;
        bus_write(4'd14, 32'h1, 4'h1);
        high_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (core_start) high_cnt++;
            else if (high_cnt > 0) break;
            @(negedge clk);
        end
        checks++;
        if (high_cnt !== 16) begin errors++; $display("FAIL timeout_length got=%0d exp=%0d", high_cnt, 16); end
        bus_read(4'd12, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL status_timeout got=%h exp=%h", rd, 32'h2); end
        bus_read(4'd13, rd);
        checks++;
        if (rd !== 32'd16) begin errors++; $display("FAIL timeout_count got=%0d exp=%0d", rd, 16); end
        checks++;
        if (core_start !== 1'b0) begin errors++; $display("FAIL timeout_core_start got=%b exp=0", core_start); end
        bus_write(4'd14, 32'h0, 4'h1);
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        bus_write(4'd0, 32'h0, 4'hF);
        bus_write(4'd14, 32'h1, 4'h1);
        bus_write(4'd0, 32'hDEAD_BEEF, 4'b0010);
        bus_read(4'd0, rd);
        checks++;
        if (rd !== 32'h0000_BE00) begin errors++; $display("FAIL byte_lane got=%h exp=%h", rd, 32'h0000_BE00); end
        checks++;
        if (core_priv_key[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL shadow_stable got=%h exp=%h", core_priv_key[31:0], 32'h0);
        end
        bus_read(4'd12, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL status_busy got=%h exp=%h", rd, 32'h4); end
        // abort during RUN returns to IDLE without setting done
        bus_write(4'd14, 32'h0, 4'h1);
        bus_read(4'd15, rd);
        checks++;
        if (rd !== 32'h0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL abort done=%h core_start=%b exp 0/0", rd, core_start);
        end
    endtask

    task automatic test_rw_same_addr();
        @(negedge clk);
        avs_address    = 4'd11;
        avs_writedata  = 32'h1;
        avs_byteenable = 4'hF;
        avs_write      = 1'b1;
        avs_read       = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        checks++;
        if (avs_readdata !== 32'h0) begin errors++; $display("FAIL rw_same_addr got=%h exp=%h", avs_readdata, 32'h0); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] rd;
        bus_write(4'd14, 32'h1, 4'h1);
        for (int c = 0; c < 3; c++) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (core_start !== 1'b0) begin errors++; $display("FAIL async_reset core_start=%b exp=0", core_start); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            checks++;
            if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_read addr=%0d got=%h exp=%h", a, rd, 32'h0); end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        avs_address    = 4'd0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_byteenable = 4'h0;
        avs_writedata  = 32'h0;
        core_done      = 1'b0;
        core_invalid   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_normal_run();
        test_invalid_irq();
        test_timeout();
        test_byte_lanes();
        test_rw_same_addr();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
